channel_scan_sequencer: RTL and testbench

Parametrised successor to the filter-bank scan controller. On a trigger it walks every enabled analysis channel for a fixed slot length each. It drives the channel-select bus, a slot-start load strobe and an end-of-frame clear strobe toward the shift-out and accumulator-reset logic. It adds a per-channel enable mask, continuous free-run mode, abort, back-to-back retrigger and an overrun flag.

---
 rtl/scan_pkg.sv | 15 +
 rtl/channel_scan_sequencer_if.sv | 34 +++
 rtl/scan_next_ch.sv | 34 +++
 rtl/channel_scan_sequencer.sv | 103 ++++++++++
 tb/tb_channel_scan_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared state encoding and default geometry for the channel scan sequencer.
// No logic; no latency.
// No flow control.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } scan_state_e;

    localparam int NUM_CH_DEF   = 16;
    localparam int SLOT_LEN_DEF = 12;

endpackage

// File: rtl/channel_scan_sequencer_if.sv
// Control/status bundle between the frame trigger source and the scan sequencer.
// Wires only; no latency.
// No backpressure: trig is a level request, overrun reports dropped requests.
interface channel_scan_sequencer_if
    import scan_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SLOT_LEN = SLOT_LEN_DEF
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(SLOT_LEN);

    logic              trig;
    logic              cont;
    logic              abort;
    logic [NUM_CH-1:0] ch_mask;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  slot_cnt;
    logic              load;
    logic              clr;
    logic              busy;
    logic              overrun;

    modport master (
        input  trig, cont, abort, ch_mask,
        output sel, slot_cnt, load, clr, busy, overrun
    );

    modport slave (
        output trig, cont, abort, ch_mask,
        input  sel, slot_cnt, load, clr, busy, overrun
    );

endinterface

// File: rtl/scan_next_ch.sv
// Priority search: next enabled channel above ch, and lowest enabled channel of a fresh mask.
// Purely combinational, zero cycles.
// No flow control.
module scan_next_ch
    import scan_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_q,
    input  logic [SEL_W-1:0]  ch,
    input  logic [NUM_CH-1:0] new_mask,
    output logic [SEL_W-1:0]  nxt_ch,
    output logic              none,
    output logic [SEL_W-1:0]  first_ch
);

    // Scanning downward lets the last hit be the lowest qualifying index.
    always_comb begin
        nxt_ch   = '0;
        none     = 1'b1;
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch))) begin
                nxt_ch = SEL_W'(i);
                none   = 1'b0;
            end
            if (new_mask[i]) begin
                first_ch = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/channel_scan_sequencer.sv
// Walks enabled channels for SLOT_LEN cycles each per trigger, then issues a one-cycle clr.
// Latency: load/sel valid the cycle after trig is sampled; frame = E*SLOT_LEN + 1 cycles.
// No backpressure: trig during SCAN is dropped and flagged by a one-cycle overrun pulse.
module channel_scan_sequencer
    import scan_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SLOT_LEN = SLOT_LEN_DEF
) (
    input logic clk,
    input logic rst_n,
    channel_scan_sequencer_if.master bus
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(SLOT_LEN);

    scan_state_e       state, state_d;
    logic [SEL_W-1:0]  ch, ch_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              ovr_q, ovr_d;

    logic [SEL_W-1:0]  nxt_ch;
    logic              none;
    logic [SEL_W-1:0]  first_ch;

    scan_next_ch #(.NUM_CH(NUM_CH)) u_next (
        .mask_q   (mask_q),
        .ch       (ch),
        .new_mask (bus.ch_mask),
        .nxt_ch   (nxt_ch),
        .none     (none),
        .first_ch (first_ch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ch     <= '0;
            cnt    <= '0;
            mask_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_d;
            ch     <= ch_d;
            cnt    <= cnt_d;
            mask_q <= mask_d;
            ovr_q  <= ovr_d;
        end
    end

    always_comb begin
        state_d = state;
        ch_d    = ch;
        cnt_d   = cnt;
        mask_d  = mask_q;
        ovr_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.trig && (bus.ch_mask != '0)) begin
                    mask_d  = bus.ch_mask;
                    ch_d    = first_ch;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A request arriving mid-frame is never queued, only reported.
                ovr_d = bus.trig;
                if (bus.abort) begin
                    state_d = ST_FLUSH;
                end else if (cnt == CNT_W'(SLOT_LEN - 1)) begin
                    cnt_d = '0;
                    if (none) begin
                        state_d = ST_FLUSH;
                    end else begin
                        ch_d = nxt_ch;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                if (!bus.abort && (bus.cont || bus.trig) && (bus.ch_mask != '0)) begin
                    mask_d  = bus.ch_mask;
                    ch_d    = first_ch;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sel      = (state == ST_SCAN) ? ch : '0;
    assign bus.slot_cnt = (state == ST_SCAN) ? cnt : '0;
    assign bus.load     = (state == ST_SCAN) && (cnt == '0);
    assign bus.clr      = (state == ST_FLUSH);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Directed bench for channel_scan_sequencer at NUM_CH=16, SLOT_LEN=12.
// Output vector per check: {sel, slot_cnt, load, clr, busy, overrun}.
module tb_channel_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    channel_scan_sequencer_if #(.NUM_CH(16), .SLOT_LEN(12)) bus ();

    channel_scan_sequencer #(.NUM_CH(16), .SLOT_LEN(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs();
        return {20'h0, bus.sel, bus.slot_cnt, bus.load, bus.clr, bus.busy, bus.overrun};
    endfunction

    // Expected outputs at cycle n (1-based) of a frame over mask m.
    function automatic logic [31:0] exp_vec(input logic [15:0] m, input int n, input logic ovr);
        int e, k, c, idx, seen;
        e    = $countones(m);
        idx  = 0;
        seen = 0;
        if (n <= e * 12) begin
            k = (n - 1) / 12;
            c = (n - 1) % 12;
            for (int i = 0; i < 16; i++) begin
                if (m[i]) begin
                    if (seen == k) idx = i;
                    seen++;
                end
            end
            return {20'h0, 4'(idx), 4'(c), (c == 0), 1'b0, 1'b1, ovr};
        end
        return {20'h0, 8'h00, 1'b0, 1'b1, 1'b1, ovr};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %03h expected %03h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at cycle 1 of a frame; leaves one cycle after its FLUSH.
    task automatic run_frame(input string tag, input logic [15:0] m, input int trig_at);
        int len;
        len = $countones(m) * 12 + 1;
        for (int n = 1; n <= len; n++) begin
            check($sformatf("%s n=%0d", tag, n), obs(),
                  exp_vec(m, n, (trig_at > 0) && (trig_at < len) && (n == trig_at + 1)));
            if (n == trig_at) bus.trig = 1'b1;
            step();
            bus.trig = 1'b0;
        end
    endtask

    task automatic start(input logic [15:0] m);
        bus.ch_mask = m;
        bus.trig    = 1'b1;
        step();
        bus.trig    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.trig    = 1'b0;
        bus.cont    = 1'b0;
        bus.abort   = 1'b0;
        bus.ch_mask = '0;
        #12;
        check("reset", obs(), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle after reset", obs(), 32'h0);

        start(16'hFFFF);
        run_frame("full", 16'hFFFF, 0);
        check("full idle", obs(), 32'h0);

        start(16'h8005);
        bus.ch_mask = 16'hFFFF;
        run_frame("sparse", 16'h8005, 0);
        check("sparse idle", obs(), 32'h0);

        bus.cont = 1'b1;
        start(16'h0003);
        run_frame("cont0", 16'h0003, 0);
        run_frame("cont1", 16'h0003, 0);
        bus.cont = 1'b0;
        run_frame("cont2", 16'h0003, 0);
        check("cont idle", obs(), 32'h0);

        start(16'hFFFF);
        run_frame("ovr", 16'hFFFF, 37);
        check("ovr idle", obs(), 32'h0);

        start(16'h0011);
        bus.ch_mask = 16'h0110;
        run_frame("rtrg0", 16'h0011, 25);
        run_frame("rtrg1", 16'h0110, 0);
        check("rtrg idle", obs(), 32'h0);

        start(16'hFFFF);
        for (int n = 1; n <= 68; n++) begin
            check($sformatf("abort n=%0d", n), obs(), exp_vec(16'hFFFF, n, 1'b0));
            if (n == 68) bus.abort = 1'b1;
            step();
        end
        bus.abort = 1'b0;
        check("abort flush", obs(), 32'h006);
        step();
        check("abort idle", obs(), 32'h0);

        bus.abort = 1'b1;
        step();
        check("abort in idle", obs(), 32'h0);
        start(16'hFFFF);
        check("trig with abort", obs(), exp_vec(16'hFFFF, 1, 1'b0));
        step();
        check("held abort flush", obs(), 32'h006);
        step();
        check("held abort idle", obs(), 32'h0);
        bus.abort = 1'b0;

        start(16'hFFFF);
        step();
        step();
        check("pre-reset scan", obs(), exp_vec(16'hFFFF, 3, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", obs(), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        check("post reset idle0", obs(), 32'h0);
        step();
        check("post reset idle1", obs(), 32'h0);

        bus.ch_mask = 16'h0000;
        bus.trig    = 1'b1;
        step();
        check("zero mask0", obs(), 32'h0);
        step();
        check("zero mask1", obs(), 32'h0);
        bus.trig = 1'b0;
        step();
        check("zero mask2", obs(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
